// File: rtl/flow_isa_pkg.sv
// ISA constants, FSM state type and the decoded control bundle for flow_sequencer.
// The PAUSE state exists only when FLOW_SINGLE_STEP_EN is defined.
package flow_isa_pkg;

  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] OP_ALU_MAX = 4'h9;
  localparam logic [3:0] OP_LDI     = 4'hA;
  localparam logic [3:0] OP_LDM     = 4'hB;
  localparam logic [3:0] OP_STM     = 4'hC;
  localparam logic [3:0] OP_LDS     = 4'hD;
  localparam logic [3:0] OP_STS     = 4'hE;
  localparam logic [3:0] OP_BRZ     = 4'hF;

  typedef enum logic [1:0] {
    LD_NONE = 2'b00,
    LD_ALU  = 2'b01,
    LD_MEM  = 2'b10,
    LD_STK  = 2'b11
  } load_src_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
`ifdef FLOW_SINGLE_STEP_EN
    , ST_PAUSE
`endif
  } state_t;

  typedef struct packed {
    logic        pc_inc;
    logic [3:0]  alu_op;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic        a_src;
    logic        b_src;
    logic [15:0] a_alt;
    logic [15:0] b_alt;
    logic [3:0]  out_sel;
    load_src_t   load_src;
    logic        st_mem;
    logic        st_stk;
  } ctrl_t;

endpackage

// File: rtl/flow_sequencer_if.sv
// Datapath-facing bundle: instruction/flags into the sequencer, control out to the datapath.
interface flow_sequencer_if;
  logic [15:0] current_instruction;
  logic [15:0] zeroflag;
  logic        program_counter_increment;
  logic [3:0]  alu_op;
  logic [3:0]  alu_a_select;
  logic [3:0]  alu_b_select;
  logic        alu_a_source;
  logic        alu_b_source;
  logic [15:0] alu_a_altern;
  logic [15:0] alu_b_altern;
  logic [3:0]  alu_out_select;
  logic [1:0]  alu_load_src;
  logic        alu_store_to_mem;
  logic        alu_store_to_stk;

  modport master (
    input  current_instruction, zeroflag,
    output program_counter_increment, alu_op, alu_a_select, alu_b_select,
           alu_a_source, alu_b_source, alu_a_altern, alu_b_altern,
           alu_out_select, alu_load_src, alu_store_to_mem, alu_store_to_stk
  );

  modport slave (
    output current_instruction, zeroflag,
    input  program_counter_increment, alu_op, alu_a_select, alu_b_select,
           alu_a_source, alu_b_source, alu_a_altern, alu_b_altern,
           alu_out_select, alu_load_src, alu_store_to_mem, alu_store_to_stk
  );
endinterface

// File: rtl/flow_decoder.sv
// Combinational EXEC-cycle decode of the instruction register into the control bundle.
module flow_decoder
  import flow_isa_pkg::*;
#(
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic [15:0] ir,
  input  logic [15:0] zeroflag,
  output ctrl_t       ctrl,
  output logic        is_halt
);

  logic [3:0] op, d, a;

  assign op = ir[15:12];
  assign d  = ir[11:8];
  assign a  = ir[7:4];

  // NOTE: every output gets a default before any branch so no path leaves a latch.
  always_comb begin
    ctrl        = '0;
    ctrl.pc_inc = 1'b1;
    is_halt     = (ir == HALT_WORD);

    if (is_halt) begin
      ctrl.pc_inc = 1'b0;
    end else if (op <= OP_ALU_MAX) begin
      ctrl.alu_op   = op;
      ctrl.a_sel    = a;
      ctrl.b_sel    = ir[3:0];
      ctrl.out_sel  = d;
      ctrl.load_src = LD_ALU;
      ctrl.pc_inc   = (d != 4'd0);
    end else begin
      // Non-ALU ops all compute through ADD; loads/stores/branch add 0 to reg[a].
      ctrl.alu_op = ALU_ADD;
      unique case (op)
        OP_LDI: begin
          ctrl.a_alt    = {{8{ir[7]}}, ir[7:0]};
          ctrl.a_src    = 1'b1;
          ctrl.b_src    = 1'b1;
          ctrl.out_sel  = d;
          ctrl.load_src = LD_ALU;
          ctrl.pc_inc   = (d != 4'd0);
        end
        OP_LDM, OP_LDS: begin
          ctrl.a_sel    = a;
          ctrl.b_src    = 1'b1;
          ctrl.out_sel  = d;
          ctrl.load_src = (op == OP_LDM) ? LD_MEM : LD_STK;
          ctrl.pc_inc   = (d != 4'd0);
        end
        OP_STM, OP_STS: begin
          ctrl.a_sel   = a;
          ctrl.b_src   = 1'b1;
          ctrl.out_sel = d;
          ctrl.st_mem  = (op == OP_STM);
          ctrl.st_stk  = (op == OP_STS);
        end
        default: begin
          if (zeroflag[d]) begin
            ctrl.a_sel    = a;
            ctrl.b_src    = 1'b1;
            ctrl.load_src = LD_ALU;
            ctrl.pc_inc   = 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/flow_sequencer.sv
// Fetch/execute sequencer driving a falling-edge-commit datapath.
// Optional single-step mode (PAUSE state and step port) under FLOW_SINGLE_STEP_EN.
module flow_sequencer
  import flow_isa_pkg::*;
#(
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
`ifdef FLOW_SINGLE_STEP_EN
  input  logic                step,
`endif
  flow_sequencer_if.master    dp,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         retired_count
);

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] retired_q;
  ctrl_t       dec_ctrl, ctrl;
  logic        is_halt;

  flow_decoder #(.HALT_WORD(HALT_WORD)) u_decoder (
    .ir       (ir_q),
    .zeroflag (dp.zeroflag),
    .ctrl     (dec_ctrl),
    .is_halt  (is_halt)
  );

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      if (state_q == ST_FETCH) ir_q <= dp.current_instruction;
      if (state_q == ST_EXEC && retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
    end
  end

  // Control outputs are live only in EXEC; every other state drives zeros.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        ctrl = dec_ctrl;
`ifdef FLOW_SINGLE_STEP_EN
        state_d = is_halt ? ST_HALT : ST_PAUSE;
`else
        state_d = is_halt ? ST_HALT : ST_FETCH;
`endif
      end
`ifdef FLOW_SINGLE_STEP_EN
      ST_PAUSE: if (step) state_d = ST_FETCH;
`endif
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign dp.program_counter_increment = ctrl.pc_inc;
  assign dp.alu_op           = ctrl.alu_op;
  assign dp.alu_a_select     = ctrl.a_sel;
  assign dp.alu_b_select     = ctrl.b_sel;
  assign dp.alu_a_source     = ctrl.a_src;
  assign dp.alu_b_source     = ctrl.b_src;
  assign dp.alu_a_altern     = ctrl.a_alt;
  assign dp.alu_b_altern     = ctrl.b_alt;
  assign dp.alu_out_select   = ctrl.out_sel;
  assign dp.alu_load_src     = ctrl.load_src;
  assign dp.alu_store_to_mem = ctrl.st_mem;
  assign dp.alu_store_to_stk = ctrl.st_stk;

  assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted        = (state_q == ST_HALT);
  assign retired_count = retired_q;

endmodule

// File: tb/tb_flow_sequencer.sv
// Directed bench for flow_sequencer: expected decode pushed per instruction, popped in EXEC.
// Build with FLOW_SINGLE_STEP_EN to exercise the PAUSE/step path.
module tb_flow_sequencer;

  typedef struct packed {
    logic        inc;
    logic [3:0]  op;
    logic [3:0]  asel;
    logic [3:0]  bsel;
    logic        asrc;
    logic        bsrc;
    logic [15:0] aalt;
    logic [15:0] balt;
    logic [3:0]  outsel;
    logic [1:0]  ld;
    logic        stm;
    logic        sts;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
`ifdef FLOW_SINGLE_STEP_EN
  logic        step;
`endif
  logic        busy, halted;
  logic [15:0] retired_count;

  int checks   = 0;
  int failures = 0;
  int n_issued = 0;
  exp_t sb[$];

  flow_sequencer_if dp ();

  flow_sequencer #(.HALT_WORD(16'hFFFF)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .start         (start),
`ifdef FLOW_SINGLE_STEP_EN
    .step          (step),
`endif
    .dp            (dp.master),
    .busy          (busy),
    .halted        (halted),
    .retired_count (retired_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ctrl_bits();
    return {9'd0, dp.program_counter_increment, dp.alu_op, dp.alu_a_select, dp.alu_b_select,
            dp.alu_a_source, dp.alu_b_source, dp.alu_a_altern, dp.alu_b_altern,
            dp.alu_out_select, dp.alu_load_src, dp.alu_store_to_mem, dp.alu_store_to_stk};
  endfunction

  // Reference decode written from the ISA description.
  function automatic exp_t model(input logic [15:0] w, input logic [15:0] zf);
    exp_t e;
    logic [3:0] opc, d, a, b;
    {opc, d, a, b} = w;
    e = '0;
    if (w == 16'hFFFF) return e;
    e.inc = 1'b1;
    if (opc < 4'hA) begin
      e.op = opc; e.asel = a; e.bsel = b; e.outsel = d; e.ld = 2'b01;
      if (d == 4'd0) e.inc = 1'b0;
    end else if (opc == 4'hA) begin
      e.aalt = {{8{w[7]}}, w[7:0]}; e.asrc = 1'b1; e.bsrc = 1'b1;
      e.outsel = d; e.ld = 2'b01;
      if (d == 4'd0) e.inc = 1'b0;
    end else if (opc == 4'hB || opc == 4'hD) begin
      e.asel = a; e.bsrc = 1'b1; e.outsel = d;
      e.ld = (opc == 4'hB) ? 2'b10 : 2'b11;
      if (d == 4'd0) e.inc = 1'b0;
    end else if (opc == 4'hC || opc == 4'hE) begin
      e.asel = a; e.bsrc = 1'b1; e.outsel = d;
      e.stm = (opc == 4'hC); e.sts = (opc == 4'hE);
    end else if (zf[d]) begin
      e.asel = a; e.bsrc = 1'b1; e.ld = 2'b01; e.inc = 1'b0;
    end
    return e;
  endfunction

  task automatic compare_exec(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_inc"},  64'(dp.program_counter_increment), 64'(e.inc));
    check({tag, "_op"},   64'(dp.alu_op),           64'(e.op));
    check({tag, "_asel"}, 64'(dp.alu_a_select),     64'(e.asel));
    check({tag, "_bsel"}, 64'(dp.alu_b_select),     64'(e.bsel));
    check({tag, "_src"},  64'({dp.alu_a_source, dp.alu_b_source}), 64'({e.asrc, e.bsrc}));
    check({tag, "_aalt"}, 64'(dp.alu_a_altern),     64'(e.aalt));
    check({tag, "_balt"}, 64'(dp.alu_b_altern),     64'(e.balt));
    check({tag, "_out"},  64'(dp.alu_out_select),   64'(e.outsel));
    check({tag, "_ld"},   64'(dp.alu_load_src),     64'(e.ld));
    check({tag, "_st"},   64'({dp.alu_store_to_mem, dp.alu_store_to_stk}), 64'({e.stm, e.sts}));
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  // Entered at a negedge in FETCH; leaves at a negedge in the next FETCH (or HALT).
  task automatic issue(input string tag, input logic [15:0] w, input logic [15:0] zf);
    dp.current_instruction = w;
    dp.zeroflag            = zf;
    sb.push_back(model(w, zf));
    n_issued++;
    @(posedge clock);
    @(negedge clock);
    compare_exec(tag);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_after_ctrl0"}, ctrl_bits(), 64'd0);
    check({tag, "_retired"}, 64'(retired_count), 64'(n_issued));
    if (w == 16'hFFFF) begin
      check({tag, "_halted"}, 64'({halted, busy}), 64'b10);
    end else begin
      check({tag, "_busy_after"}, 64'({halted, busy}), 64'b01);
`ifdef FLOW_SINGLE_STEP_EN
      repeat (2) @(negedge clock);
      check({tag, "_pause_hold"}, 64'(retired_count), 64'(n_issued));
      check({tag, "_pause_busy"}, 64'(busy), 64'd1);
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
`endif
    end
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
`ifdef FLOW_SINGLE_STEP_EN
    step   = 1'b0;
`endif
    dp.current_instruction = 16'h0000;
    dp.zeroflag            = 16'h0000;
    repeat (2) @(negedge clock);
    check("rst_status", 64'({busy, halted}), 64'd0);
    check("rst_retired", 64'(retired_count), 64'd0);
    check("rst_ctrl", ctrl_bits(), 64'd0);

    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_wait_start", 64'(busy), 64'd0);

    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("fetch_busy", 64'(busy), 64'd1);
    check("fetch_ctrl0", ctrl_bits(), 64'd0);

    issue("alu_0312", 16'h0312, 16'h0000);
    issue("ldi_a2f0", 16'hA2F0, 16'h0000);
    issue("stm_c541", 16'hC541, 16'h0000);
    issue("brz_taken", 16'hF170, 16'h0002);
    issue("brz_not", 16'hF170, 16'hFFFD);
    issue("alu_d0", 16'h0012, 16'h0000);
    issue("ldm_b3a0", 16'hB3A0, 16'h0000);
    issue("lds_d4b0", 16'hD4B0, 16'h0000);
    issue("sts_e650", 16'hE650, 16'h0000);
    issue("alu_5789", 16'h5789, 16'h0000);
    issue("halt", 16'hFFFF, 16'h0000);
    repeat (4) @(negedge clock);
    check("halt_sticky", 64'({halted, busy, retired_count}), 64'({2'b10, 16'(n_issued)}));

    resetn = 1'b0;
    @(negedge clock);
    check("rst2_status", 64'({busy, halted, retired_count}), 64'd0);
    start  = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("rst2_needs_start", 64'(busy), 64'd0);

    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    dp.current_instruction = 16'h0312;
    @(posedge clock);
    #2;
    check("midexec_inc", 64'(dp.program_counter_increment), 64'd1);
    resetn = 1'b0;
    #1;
    check("midexec_rst_ctrl", ctrl_bits(), 64'd0);
    check("midexec_rst_status", 64'({busy, halted, retired_count}), 64'd0);
    @(negedge clock);
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
